// File: rtl/ws_sub1_pkg.sv
// ws_sub1_pkg: bus widths and payload layout shared by the
// writeback stages of both sub-pipes.
package ws_sub1_pkg;

   localparam int M2S_TO_WS_BUS_WD = 75;
   localparam int WS_TO_RF_BUS_WD  = 41;
   localparam int WS_FWD_BUS_WD    = 39;

   typedef struct packed {
      logic        first;
      logic [3:0]  rf_wen;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } m2s_ws_t;

endpackage

// File: rtl/ws_sub1.sv
// ws_sub1: writeback stage of sub-pipe 1. Holds one MEM2 payload,
// writes the register file, and feeds forwarding, trace and retire count.
module ws_sub1
   import ws_sub1_pkg::*;
#(
   parameter int BUS_WD = M2S_TO_WS_BUS_WD,
   parameter int FWD_WD = WS_FWD_BUS_WD,
   parameter int RF_WD  = WS_TO_RF_BUS_WD,
   parameter int CNT_WD = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ws_stall,
   input  logic              m2s_to_ws_valid,
   input  logic [BUS_WD-1:0] m2s_to_ws_bus,
   output logic              ws_allowin,
   output logic [RF_WD-1:0]  ws_to_rf_bus,
   output logic [FWD_WD-1:0] ws_fwd_bus,
   output logic              ws_first,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [4:0]        debug_wb_rf_wnum,
   output logic [31:0]       debug_wb_rf_wdata,
   output logic [CNT_WD-1:0] retire_cnt
);

   logic              r_ws_valid;
   logic [BUS_WD-1:0] r_payload;
   logic [CNT_WD-1:0] r_retire_cnt;

   m2s_ws_t           w_pl;
   logic              w_ready_go;
   logic              w_commit;
   logic              w_dest_nz;
   logic              w_eff_we;
   logic [3:0]        w_wen;

   assign w_pl       = m2s_ws_t'(r_payload[M2S_TO_WS_BUS_WD-1:0]);
   assign w_ready_go = ~ws_stall;
   assign ws_allowin = ~r_ws_valid | w_ready_go;
   assign w_commit   = r_ws_valid & w_ready_go;
   assign w_dest_nz  = (w_pl.dest != 5'd0);
   assign w_eff_we   = w_commit & w_pl.gr_we & w_dest_nz;
   assign w_wen      = {4{w_eff_we}} & w_pl.rf_wen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ws_valid   <= 1'b0;
         r_payload    <= '0;
         r_retire_cnt <= '0;
      end else begin
         if (ws_allowin)
            r_ws_valid <= m2s_to_ws_valid;
         if (ws_allowin && m2s_to_ws_valid)
            r_payload <= m2s_to_ws_bus;
         if (w_commit)
            r_retire_cnt <= r_retire_cnt + {{(CNT_WD-1){1'b0}}, 1'b1};
      end
   end

   assign ws_to_rf_bus = {w_wen, w_pl.dest, w_pl.result};

   // Forwarding stays live while stalled: the held value is the youngest producer.
   assign ws_fwd_bus = {r_ws_valid,
                        r_ws_valid & w_pl.gr_we & w_dest_nz,
                        w_pl.dest,
                        w_pl.result};

   assign ws_first          = w_pl.first & r_ws_valid;
   assign debug_wb_pc       = w_pl.pc;
   assign debug_wb_rf_wen   = w_wen;
   assign debug_wb_rf_wnum  = w_pl.dest;
   assign debug_wb_rf_wdata = w_pl.result;
   assign retire_cnt        = r_retire_cnt;

endmodule

// File: tb/tb_ws_sub1.sv
// tb_ws_sub1: scoreboard bench for the sub-pipe 1 writeback stage.
// A narrow-counter second instance exercises retire counter wrap.
module tb_ws_sub1;

   logic        clk;
   logic        reset;
   logic        ws_stall;
   logic        m2s_to_ws_valid;
   logic [74:0] m2s_to_ws_bus;
   logic        ws_allowin;
   logic [40:0] ws_to_rf_bus;
   logic [38:0] ws_fwd_bus;
   logic        ws_first;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [31:0] retire_cnt;

   logic        w_allowin;
   logic [40:0] w_rf_bus;
   logic [38:0] w_fwd_bus;
   logic        w_first;
   logic [31:0] w_pc;
   logic [3:0]  w_wen;
   logic [4:0]  w_wnum;
   logic [31:0] w_wdata;
   logic [3:0]  w_cnt;

   typedef struct {
      logic [3:0]  wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        rw;
      logic        first;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          errors;
   logic [31:0] m_cnt;

   ws_sub1 dut (
      .clk               (clk),
      .reset             (reset),
      .ws_stall          (ws_stall),
      .m2s_to_ws_valid   (m2s_to_ws_valid),
      .m2s_to_ws_bus     (m2s_to_ws_bus),
      .ws_allowin        (ws_allowin),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .ws_fwd_bus        (ws_fwd_bus),
      .ws_first          (ws_first),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .retire_cnt        (retire_cnt)
   );

   ws_sub1 #(.CNT_WD(4)) u_wrap (
      .clk               (clk),
      .reset             (reset),
      .ws_stall          (ws_stall),
      .m2s_to_ws_valid   (m2s_to_ws_valid),
      .m2s_to_ws_bus     (m2s_to_ws_bus),
      .ws_allowin        (w_allowin),
      .ws_to_rf_bus      (w_rf_bus),
      .ws_fwd_bus        (w_fwd_bus),
      .ws_first          (w_first),
      .debug_wb_pc       (w_pc),
      .debug_wb_rf_wen   (w_wen),
      .debug_wb_rf_wnum  (w_wnum),
      .debug_wb_rf_wdata (w_wdata),
      .retire_cnt        (w_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic put(input logic f, input logic [3:0] rfw,
                      input logic gw, input logic [4:0] d,
                      input logic [31:0] r, input logic [31:0] p);
      exp_t e;
      m2s_to_ws_valid = 1'b1;
      m2s_to_ws_bus   = {f, rfw, gw, d, r, p};
      e.wen   = (gw && d != 5'd0) ? rfw : 4'h0;
      e.waddr = d;
      e.wdata = r;
      e.pc    = p;
      e.rw    = gw && (d != 5'd0);
      e.first = f;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      m2s_to_ws_valid = 1'b0;
      ws_stall = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      m_cnt = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ws_stall = 1'b0;
      m2s_to_ws_valid = 1'b1;
      m2s_to_ws_bus = {1'b1, 4'hF, 1'b1, 5'd7, 32'hDEADBEEF, 32'h1C};
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ws_allowin !== 1'b1) begin
         errors++; $display("FAIL rst_allowin got %b exp 1", ws_allowin);
      end
      checks++;
      if (ws_fwd_bus !== 39'd0) begin
         errors++; $display("FAIL rst_fwd got %h exp 0", ws_fwd_bus);
      end
      checks++;
      if (debug_wb_rf_wen !== 4'h0 || retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_wen_cnt got %h/%h exp 0/0", debug_wb_rf_wen, retire_cnt);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      m2s_to_ws_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ws_fwd_bus[38] !== 1'b1 || ws_first !== 1'b1) begin
         errors++;
         $display("FAIL cap_valid got %b/%b exp 1/1", ws_fwd_bus[38], ws_first);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ws_fwd_bus[38] !== 1'b0 || ws_allowin !== 1'b1 || ws_first !== 1'b0) begin
         errors++;
         $display("FAIL async_rst got v%b a%b f%b exp 0/1/0",
                  ws_fwd_bus[38], ws_allowin, ws_first);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      m_cnt = 32'd0;
   endtask

   task automatic test_basic(input logic [4:0] d, input string nm);
      exp_t e;
      @(posedge clk); #1;
      put(1'b0, 4'hF, 1'b1, d, 32'h12345678, 32'hBFC00000);
      @(posedge clk); #1;
      m2s_to_ws_valid = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ws_to_rf_bus !== {e.wen, e.waddr, e.wdata}) begin
         errors++;
         $display("FAIL %s_rf got %h exp %h", nm, ws_to_rf_bus, {e.wen, e.waddr, e.wdata});
      end
      checks++;
      if (ws_fwd_bus !== {1'b1, e.rw, e.waddr, e.wdata}) begin
         errors++;
         $display("FAIL %s_fwd got %h exp %h", nm, ws_fwd_bus, {1'b1, e.rw, e.waddr, e.wdata});
      end
      checks++;
      if (debug_wb_pc !== e.pc || debug_wb_rf_wen !== e.wen ||
          debug_wb_rf_wnum !== e.waddr || debug_wb_rf_wdata !== e.wdata) begin
         errors++;
         $display("FAIL %s_trace got %h %h %h %h exp %h %h %h %h", nm,
                  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
                  e.pc, e.wen, e.waddr, e.wdata);
      end
      m_cnt++;
      @(negedge clk);
      checks++;
      if (retire_cnt !== m_cnt || debug_wb_rf_wen !== 4'h0) begin
         errors++;
         $display("FAIL %s_cnt got %0d wen %h exp %0d wen 0", nm,
                  retire_cnt, debug_wb_rf_wen, m_cnt);
      end
   endtask

   task automatic test_stall(input logic pre_fill);
      exp_t e;
      @(posedge clk); #1;
      ws_stall = ~pre_fill;
      put(1'b1, 4'h3, 1'b1, 5'd9, 32'hCAFE0009, 32'h00000040);
      if (!pre_fill) begin
         @(negedge clk);
         checks++;
         if (ws_allowin !== 1'b1) begin
            errors++; $display("FAIL stall_empty_allowin got %b exp 1", ws_allowin);
         end
      end
      @(posedge clk); #1;
      m2s_to_ws_valid = 1'b0;
      ws_stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (ws_allowin !== 1'b0 || debug_wb_rf_wen !== 4'h0 ||
             ws_fwd_bus[38:37] !== 2'b11 || retire_cnt !== m_cnt) begin
            errors++;
            $display("FAIL stall_hold got a%b w%h f%b c%0d exp 0 0 11 %0d",
                     ws_allowin, debug_wb_rf_wen, ws_fwd_bus[38:37], retire_cnt, m_cnt);
         end
      end
      @(posedge clk); #1;
      ws_stall = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ws_to_rf_bus !== {e.wen, e.waddr, e.wdata} || debug_wb_pc !== e.pc) begin
         errors++;
         $display("FAIL unstall_wr got %h pc %h exp %h pc %h", ws_to_rf_bus,
                  debug_wb_pc, {e.wen, e.waddr, e.wdata}, e.pc);
      end
      m_cnt++;
      @(negedge clk);
      checks++;
      if (retire_cnt !== m_cnt || debug_wb_rf_wen !== 4'h0) begin
         errors++;
         $display("FAIL unstall_cnt got %0d wen %h exp %0d wen 0",
                  retire_cnt, debug_wb_rf_wen, m_cnt);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i < 4)
            put(i[0], 4'hF, 1'b1, 5'(i + 1), 32'hA0000000 + 32'(i), 32'h100 + 32'(4 * i));
         else
            m2s_to_ws_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (retire_cnt !== m_cnt || ws_allowin !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cnt%0d got %0d a%b exp %0d a1", i, retire_cnt, ws_allowin, m_cnt);
         end
         if (i >= 1 && i <= 4) begin
            e = sb.pop_front();
            checks++;
            if (ws_to_rf_bus !== {e.wen, e.waddr, e.wdata} || ws_first !== e.first) begin
               errors++;
               $display("FAIL b2b_wr%0d got %h f%b exp %h f%b", i, ws_to_rf_bus,
                        ws_first, {e.wen, e.waddr, e.wdata}, e.first);
            end
            m_cnt++;
         end
      end
      checks++;
      if (retire_cnt !== 32'd4) begin
         errors++; $display("FAIL b2b_total got %0d exp 4", retire_cnt);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      put(1'b0, 4'hF, 1'b1, 5'd3, 32'h33333333, 32'h200);
      @(posedge clk); #1;
      m2s_to_ws_valid = 1'b0;
      ws_stall = 1'b1;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      ws_stall = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (debug_wb_rf_wen !== 4'h0 || retire_cnt !== 32'd0 || ws_fwd_bus[38] !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall got w%h c%0d v%b exp 0 0 0",
                     debug_wb_rf_wen, retire_cnt, ws_fwd_bus[38]);
         end
      end
      m_cnt = 32'd0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(posedge clk); #1;
         m2s_to_ws_valid = 1'b1;
         m2s_to_ws_bus = {1'b0, 4'h1, 1'b0, 5'd1, 32'(k), 32'h300 + 32'(4 * k)};
      end
      @(posedge clk); #1;
      m2s_to_ws_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (retire_cnt !== 32'd16 || w_cnt !== 4'h0 || debug_wb_rf_wen !== 4'h0) begin
         errors++;
         $display("FAIL wrap0 got %0d/%0d wen %h exp 16/0 wen 0",
                  retire_cnt, w_cnt, debug_wb_rf_wen);
      end
      @(negedge clk);
      checks++;
      if (retire_cnt !== 32'd17 || w_cnt !== 4'h1) begin
         errors++; $display("FAIL wrap1 got %0d/%0d exp 17/1", retire_cnt, w_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt = 32'd0;
      reset = 1'b1;
      ws_stall = 1'b0;
      m2s_to_ws_valid = 1'b0;
      m2s_to_ws_bus = '0;
      test_reset();
      test_basic(5'd5, "basic");
      test_basic(5'd0, "dest0");
      test_stall(1'b1);
      test_stall(1'b0);
      test_back_to_back();
      test_reset_mid_stall();
      test_wrap();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_left got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
